// File: rtl/vga_pkg.sv
// Shared constants, FSM state type and counter helper for the VGA plot arbiter.
package vga_pkg;

  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int COLOUR_W = 3;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int CNT_W    = 15;

  localparam logic [CNT_W-1:0] CNT_MAX = 15'h7FFF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OWN     = 2'd1,
    HANDOFF = 2'd2
  } arb_state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
    logic [CNT_W-1:0] result;
    if (value == CNT_MAX) begin
      result = value;
    end else begin
      result = value + 15'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/vga_plot_arbiter_rr_select.sv
// Round-robin pick of the next owner, searching upward from the one after last_owner.
module rr_select
  import vga_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_owner,
  output logic [NUM_REQ-1:0] sel_oh,
  output logic [IDX_W-1:0]   sel_idx
);

  logic [IDX_W-1:0] cand_s;
  logic             found_s;
  logic             hit_s;

  // Walk candidates in wrap-around order; the first requesting one wins.
  always_comb begin
    sel_oh  = '0;
    sel_idx = '0;
    found_s = 1'b0;
    cand_s  = '0;
    hit_s   = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand_s         = IDX_W'((int'(last_owner) + k) % NUM_REQ);
      hit_s          = !found_s && req[cand_s];
      sel_oh[cand_s] = hit_s ? 1'b1 : sel_oh[cand_s];
      sel_idx        = hit_s ? cand_s : sel_idx;
      found_s        = found_s | hit_s;
    end
  end

endmodule

// File: rtl/vga_plot_arbiter.sv
// Shares the vga_adapter plot port among NUM_REQ drawing engines, one job at a time,
// with round-robin ownership and no preemption.
module vga_plot_arbiter
  import vga_pkg::*;
#(
  parameter int NUM_REQ = 3
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_REQ-1:0]                req,
  input  logic [NUM_REQ-1:0][X_W-1:0]       req_x,
  input  logic [NUM_REQ-1:0][Y_W-1:0]       req_y,
  input  logic [NUM_REQ-1:0][COLOUR_W-1:0]  req_colour,
  input  logic [NUM_REQ-1:0]                req_plot,
  output logic [NUM_REQ-1:0]                gnt,
  output logic [X_W-1:0]                    vga_x,
  output logic [Y_W-1:0]                    vga_y,
  output logic [COLOUR_W-1:0]               vga_colour,
  output logic                              vga_plot,
  output logic                              busy,
  output logic [CNT_W-1:0]                  plot_count
);

  localparam int               IDX_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IDX_W-1:0] OWNER_RST  = IDX_W'(NUM_REQ - 1);

  arb_state_t            state_r, state_nxt_s;
  logic [IDX_W-1:0]      owner_r, owner_nxt_s;
  logic [NUM_REQ-1:0]    gnt_r, gnt_nxt_s;
  logic [X_W-1:0]        vga_x_r, vga_x_nxt_s;
  logic [Y_W-1:0]        vga_y_r, vga_y_nxt_s;
  logic [COLOUR_W-1:0]   vga_colour_r, vga_colour_nxt_s;
  logic                  vga_plot_r, vga_plot_nxt_s;
  logic                  busy_r, busy_nxt_s;
  logic [CNT_W-1:0]      plot_count_r, plot_count_nxt_s;
  logic [NUM_REQ-1:0]    sel_oh_s;
  logic [IDX_W-1:0]      sel_idx_s;

  // owner_r doubles as last_owner: it only changes when a new grant is made.
  rr_select #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_select (
    .req        (req),
    .last_owner (owner_r),
    .sel_oh     (sel_oh_s),
    .sel_idx    (sel_idx_s)
  );

  // Next-state and next-output logic for the ownership FSM.
  always_comb begin
    state_nxt_s      = state_r;
    owner_nxt_s      = owner_r;
    gnt_nxt_s        = gnt_r;
    vga_x_nxt_s      = vga_x_r;
    vga_y_nxt_s      = vga_y_r;
    vga_colour_nxt_s = vga_colour_r;
    vga_plot_nxt_s   = 1'b0;
    plot_count_nxt_s = plot_count_r;
    case (state_r)
      IDLE: begin
        if (|req) begin
          state_nxt_s      = OWN;
          owner_nxt_s      = sel_idx_s;
          gnt_nxt_s        = sel_oh_s;
          plot_count_nxt_s = '0;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      OWN: begin
        // A strobe coinciding with the owner's release is dropped.
        if (!req[owner_r]) begin
          state_nxt_s = HANDOFF;
          gnt_nxt_s   = '0;
        end else if (req_plot[owner_r]) begin
          vga_plot_nxt_s   = 1'b1;
          vga_x_nxt_s      = req_x[owner_r];
          vga_y_nxt_s      = req_y[owner_r];
          vga_colour_nxt_s = req_colour[owner_r];
          plot_count_nxt_s = sat_inc(plot_count_r);
        end else begin
          vga_plot_nxt_s = 1'b0;
        end
      end
      HANDOFF: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
        gnt_nxt_s   = '0;
      end
    endcase
    busy_nxt_s = (state_nxt_s != IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      owner_r      <= OWNER_RST;
      gnt_r        <= '0;
      vga_x_r      <= '0;
      vga_y_r      <= '0;
      vga_colour_r <= '0;
      vga_plot_r   <= 1'b0;
      busy_r       <= 1'b0;
      plot_count_r <= '0;
    end else begin
      state_r      <= state_nxt_s;
      owner_r      <= owner_nxt_s;
      gnt_r        <= gnt_nxt_s;
      vga_x_r      <= vga_x_nxt_s;
      vga_y_r      <= vga_y_nxt_s;
      vga_colour_r <= vga_colour_nxt_s;
      vga_plot_r   <= vga_plot_nxt_s;
      busy_r       <= busy_nxt_s;
      plot_count_r <= plot_count_nxt_s;
    end
  end

  assign gnt        = gnt_r;
  assign vga_x      = vga_x_r;
  assign vga_y      = vga_y_r;
  assign vga_colour = vga_colour_r;
  assign vga_plot   = vga_plot_r;
  assign busy       = busy_r;
  assign plot_count = plot_count_r;

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Scoreboard bench for vga_plot_arbiter: directed jobs push expected plots and grants,
// a negedge monitor pops and compares whatever the DUT presents.
module tb_vga_plot_arbiter;
  import vga_pkg::*;

  localparam int N = 3;

  logic                         clk = 1'b0;
  logic                         rst_n;
  logic [N-1:0]                 req;
  logic [N-1:0][X_W-1:0]        req_x;
  logic [N-1:0][Y_W-1:0]        req_y;
  logic [N-1:0][COLOUR_W-1:0]   req_colour;
  logic [N-1:0]                 req_plot;
  logic [N-1:0]                 gnt;
  logic [X_W-1:0]               vga_x;
  logic [Y_W-1:0]               vga_y;
  logic [COLOUR_W-1:0]          vga_colour;
  logic                         vga_plot;
  logic                         busy;
  logic [CNT_W-1:0]             plot_count;

  int           checks      = 0;
  int           failures    = 0;
  int           plot_pulses = 0;
  logic [17:0]  plot_q[$];
  logic [N-1:0] gnt_q[$];
  logic [N-1:0] prev_gnt    = '0;
  logic         saw_159     = 1'b0;

  vga_plot_arbiter #(.NUM_REQ(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .req_x      (req_x),
    .req_y      (req_y),
    .req_colour (req_colour),
    .req_plot   (req_plot),
    .gnt        (gnt),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot),
    .busy       (busy),
    .plot_count (plot_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req      = '0;
    req_plot = '0;
    rst_n    = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_gnt(input string name, output int cycles);
    cycles = 0;
    while (gnt == '0 && cycles < 16) begin
      tick();
      cycles++;
    end
    if (gnt == '0) begin
      checks++;
      failures++;
      $display("FAIL %s: no grant after %0d cycles", name, cycles);
    end
  endtask

  task automatic plot_one(input logic [1:0] e, input int x, input int y, input int c);
    req_plot      = '0;
    req_plot[e]   = 1'b1;
    req_x[e]      = 8'(x);
    req_y[e]      = 7'(y);
    req_colour[e] = 3'(c);
    plot_q.push_back({8'(x), 7'(y), 3'(c)});
    tick();
    req_plot[e] = 1'b0;
  endtask

  // Monitor: every plot pulse and every new grant must match the head of its queue.
  always @(negedge clk) begin
    if (vga_x == 8'd159) saw_159 = 1'b1;
    if (vga_plot === 1'b1) begin
      plot_pulses++;
      if (plot_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL plot_unexpected: got xyc=%0d required no plot", {vga_x, vga_y, vga_colour});
      end else begin
        check("plot_xyc", int'({vga_x, vga_y, vga_colour}), int'(plot_q.pop_front()));
      end
    end
    if (gnt !== prev_gnt && gnt !== '0) begin
      if (gnt_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL grant_unexpected: got gnt=%0d required no grant", gnt);
      end else begin
        check("grant_value", int'(gnt), int'(gnt_q.pop_front()));
      end
      check("grant_onehot", int'($onehot(gnt)), 1);
    end
    prev_gnt = gnt;
  end

  initial begin
    logic [1:0] order [4];
    logic [1:0] own;
    int cyc;
    int base;

    order      = '{2'd0, 2'd1, 2'd2, 2'd0};
    rst_n      = 1'b1;
    req        = '0;
    req_plot   = '0;
    req_x      = '0;
    req_y      = '0;
    req_colour = '0;

    // Asynchronous reset takes effect before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    check("rst_gnt", int'(gnt), 0);
    check("rst_plot", int'(vga_plot), 0);
    check("rst_xyc", int'({vga_x, vga_y, vga_colour}), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_count", int'(plot_count), 0);
    tick();
    tick();
    rst_n = 1'b1;

    // Single engine, one-cycle grant and plot latency, outputs hold between plots.
    gnt_q.push_back(3'b001);
    req = 3'b001;
    tick();
    check("t030_gnt", int'(gnt), 1);
    check("t030_busy", int'(busy), 1);
    plot_one(2'd0, 5, 7, 5);
    check("t030_plot", int'(vga_plot), 1);
    check("t030_x", int'(vga_x), 5);
    check("t030_y", int'(vga_y), 7);
    check("t030_colour", int'(vga_colour), 5);
    tick();
    check("t030_plot_low", int'(vga_plot), 0);
    check("t030_x_hold", int'(vga_x), 5);
    plot_one(2'd0, 6, 8, 2);
    req = 3'b000;
    tick();
    tick();
    tick();
    check("t030_count_hold", int'(plot_count), 2);

    // All three request; each owner leaves after four plots.
    do_reset();
    gnt_q.push_back(3'b001);
    gnt_q.push_back(3'b010);
    gnt_q.push_back(3'b100);
    gnt_q.push_back(3'b001);
    req = 3'b111;
    for (int g = 0; g < 4; g++) begin
      own = order[g];
      wait_gnt("t031_wait", cyc);
      if (g == 0) check("t031_first_latency", cyc, 1);
      else        check("t031_gap", cyc, 2);
      for (int p = 0; p < 4; p++) plot_one(own, 10 * int'(own) + p, 20 + p, p + int'(own));
      if (g == 3) req = 3'b000;
      else        req[own] = 1'b0;
      tick();
      check("t031_count_at_drop", int'(plot_count), 4);
      check("t031_gnt_clear", int'(gnt), 0);
      if (g < 3) req[own] = 1'b1;
    end
    tick();
    tick();
    check("t031_idle", int'(busy), 0);

    // Owner 1 plots while engine 2 toggles its strobe at x=159; engine 2 then quits unserved.
    do_reset();
    saw_159 = 1'b0;
    gnt_q.push_back(3'b010);
    req = 3'b110;
    tick();
    check("t032_gnt", int'(gnt), 2);
    req_x[2]      = 8'd159;
    req_y[2]      = 7'd100;
    req_colour[2] = 3'd7;
    for (int i = 0; i < 8; i++) begin
      req_plot[2] = ~req_plot[2];
      if (i % 2 == 0) begin
        req_plot[1]   = 1'b1;
        req_x[1]      = 8'(50 + i);
        req_y[1]      = 7'(i);
        req_colour[1] = 3'(i);
        plot_q.push_back({8'(50 + i), 7'(i), 3'(i)});
      end else begin
        req_plot[1] = 1'b0;
      end
      tick();
    end
    req_plot = '0;
    req      = 3'b100;
    tick();
    req = 3'b000;
    tick();
    tick();
    tick();
    check("t032_no_late_grant", int'(gnt), 0);
    check("t032_never_159", int'(saw_159), 0);

    // Release coinciding with a strobe: nothing forwarded, one HANDOFF cycle.
    do_reset();
    gnt_q.push_back(3'b001);
    req = 3'b001;
    tick();
    plot_one(2'd0, 40, 41, 6);
    req_plot[0] = 1'b1;
    req_x[0]    = 8'd33;
    req         = 3'b000;
    tick();
    check("t033_gnt", int'(gnt), 0);
    check("t033_busy_handoff", int'(busy), 1);
    check("t033_no_plot", int'(vga_plot), 0);
    req_plot = '0;
    tick();
    check("t033_busy_idle", int'(busy), 0);
    check("t033_x_hold", int'(vga_x), 40);

    // Reset in the middle of a burst, then restart with engines 1 and 2.
    do_reset();
    gnt_q.push_back(3'b001);
    req = 3'b001;
    tick();
    for (int i = 0; i < 100; i++) plot_one(2'd0, i, i % 120, i % 8);
    req_plot[0] = 1'b1;
    check("t034_count_100", int'(plot_count), 100);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("t034_gnt", int'(gnt), 0);
    check("t034_plot", int'(vga_plot), 0);
    check("t034_count", int'(plot_count), 0);
    req_plot = '0;
    req      = 3'b110;
    tick();
    tick();
    rst_n = 1'b1;
    gnt_q.push_back(3'b010);
    tick();
    check("t034_regrant", int'(gnt), 2);
    req = 3'b000;
    tick();
    tick();
    tick();

    // Full screen from one owner, then on to counter saturation.
    do_reset();
    gnt_q.push_back(3'b001);
    req = 3'b001;
    tick();
    base = plot_pulses;
    for (int i = 0; i < SCREEN_W * SCREEN_H; i++) plot_one(2'd0, i % SCREEN_W, i / SCREEN_W, i % 8);
    check("t035_count", int'(plot_count), 19200);
    @(negedge clk);
    #1;
    check("t035_pulses", plot_pulses - base, 19200);
    @(posedge clk);
    #1;
    for (int i = 19200; i < 32770; i++) plot_one(2'd0, i % SCREEN_W, (i / SCREEN_W) % SCREEN_H, i % 8);
    check("sat_count", int'(plot_count), 32767);
    req = 3'b000;
    tick();
    tick();
    tick();
    check("sat_hold_idle", int'(plot_count), 32767);

    check("plot_queue_empty", plot_q.size(), 0);
    check("grant_queue_empty", gnt_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
